adc_align_ctrl: RTL and testbench
=================================

Name: adc_align_ctrl

Overview:
Bitslip training and lock-monitor controller for the LTC2174 ISERDES2 deserializer. It runs in the divided DCO clock domain and watches the deserialized frame (FR) lane word. It issues single-cycle bitslip pulses, shared by all nine ISERDES2 pairs, until the frame word matches the expected pattern. Once aligned, it reports lock, monitors for loss of lock and can retrain automatically.

Parameters:
PATTERN, 8'hf0, expected frame-lane word when aligned.
SETTLE, 4, cycles to wait after start or after each bitslip before comparing (ISERDES pipeline flush); range 1..15.
MATCH_CNT, 16, consecutive matches required to declare lock; range 1..255.
MAX_SLIPS, 8, bitslips allowed before declaring failure; range 1..15.
LOSS_CNT, 4, consecutive mismatches while locked that declare loss of lock; range 1..15.

Ports:
clk  in  1  divided DCO clock (clkdiv domain).
rst_n  in  1  reset, synchronous, active-low.
start  in  1  single-cycle training request.
retrain_en  in  1  when 1, loss of lock starts retraining automatically.
frame_word  in  8  deserialized FR lane word, one new word per clk.
bitslip  out  1  single-cycle bitslip pulse to all ISERDES2 instances.
busy  out  1  training in progress.
locked  out  1  alignment achieved and held.
fail  out  1  training exhausted MAX_SLIPS without lock.
slip_count  out  4  bitslips issued in the current training run.
relock_count  out  8  lock-loss event counter (see Optional Feature).

Behaviour:
- Reset (rst_n=0 sampled at a clk edge): state IDLE; bitslip=0, busy=0, locked=0, fail=0, slip_count=0, relock_count=0, and all internal counters cleared. Reset overrides every other input, including a reset arriving mid-slip or mid-wait.
- States: IDLE, WAIT, CHECK, SLIP, LOCKED, FAIL. All outputs are registered.
- IDLE: start=1 -> WAIT. The transition clears slip_count, fail and the match counter, and loads the settle counter with SETTLE.
- WAIT: busy=1. The settle counter decrements each cycle; at 0 -> CHECK. frame_word is ignored in this state.
- CHECK: busy=1. Each cycle, frame_word==PATTERN increments the match counter. When the counter reaches MATCH_CNT -> LOCKED.
- CHECK mismatch: clears the match counter. If slip_count==MAX_SLIPS -> FAIL; otherwise -> SLIP.
- SLIP: bitslip=1 for exactly this one cycle; slip_count increments; settle counter reloads with SETTLE; -> WAIT. Minimum spacing between bitslip pulses is SETTLE+2 cycles.
- LOCKED: locked=1, busy=0.
  - Each mismatch increments the loss counter; a match clears it.
  - When the loss counter reaches LOSS_CNT: locked falls on the same edge and the loss counter clears.
  - If retrain_en=1 at that edge -> WAIT, as for start. If retrain_en=0 -> IDLE.
  - start=1 in LOCKED forces retraining: locked=0 -> WAIT.
- FAIL: fail=1 held until start (-> WAIT, fail cleared) or reset.
- start is ignored while busy=1.
- Lock latency with no slips: locked rises SETTLE+MATCH_CNT+1 edges after the edge sampling start.
- slip_count saturates at MAX_SLIPS and holds its value after lock or fail, until the next training starts.

Optional Feature:
ALIGN_STATS_EN:
- When defined: relock_count increments on every LOCKED loss-of-lock event and saturates at 8'hff. It is cleared only by reset.
- When undefined: relock_count is tied to 0 and no counter logic is generated.

Test Plan:
- Aligned: reset, frame_word=0xF0 constant, start pulse -> zero bitslip pulses, locked=1 exactly 21 edges after start, slip_count=0, busy=0.
- Misaligned: bench rotates its word left by 1 per bitslip, starting at 0xE1 -> exactly 7 bitslip pulses, each one cycle wide and spaced at least 6 cycles apart, then locked=1, slip_count=7.
- Failure: frame_word=0x55 constant -> 8 bitslip pulses, then fail=1, busy=0, locked=0; a subsequent start clears fail and retrains.
- Loss of lock: locked, then 3 cycles of 0x00 followed by 0xF0 -> locked stays 1.
  - With retrain_en=1, 4 cycles of 0x00 -> locked=0, busy=1 on the 4th edge, and retraining begins.
  - With ALIGN_STATS_EN defined, relock_count=1 after this event.
- Reset mid-operation: assert rst_n=0 during the SLIP cycle -> bitslip=0, all outputs at reset values on the next edge; start ignored while busy; retrain_en=0 loss -> IDLE.

Source files
------------

// File: rtl/adc_align_ctrl.sv
// Bitslip training and lock monitor for the ISERDES2 frame lane (clkdiv domain).
// Define ALIGN_STATS_EN to build the saturating loss-of-lock event counter.
module adc_align_ctrl #(
    parameter logic [7:0]  PATTERN   = 8'hf0,
    parameter int unsigned SETTLE    = 4,
    parameter int unsigned MATCH_CNT = 16,
    parameter int unsigned MAX_SLIPS = 8,
    parameter int unsigned LOSS_CNT  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       retrain_en,
    input  logic [7:0] frame_word,
    output logic       bitslip,
    output logic       busy,
    output logic       locked,
    output logic       fail,
    output logic [3:0] slip_count,
    output logic [7:0] relock_count
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT, ST_CHECK, ST_SLIP, ST_LOCKED, ST_FAIL
    } state_t;

    localparam logic [3:0] SETTLE_LD  = 4'(SETTLE);
    localparam logic [3:0] SLIP_LIMIT = 4'(MAX_SLIPS);
    localparam logic [3:0] LOSS_LAST  = 4'(LOSS_CNT - 1);
    localparam logic [7:0] MATCH_LAST = 8'(MATCH_CNT - 1);

    state_t     state_reg;
    logic [3:0] settle_reg;
    logic [7:0] match_reg;
    logic [3:0] loss_reg;
    logic       word_match;

    assign word_match = (frame_word == PATTERN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            settle_reg <= '0;
            match_reg  <= '0;
            loss_reg   <= '0;
            bitslip    <= 1'b0;
            busy       <= 1'b0;
            locked     <= 1'b0;
            fail       <= 1'b0;
            slip_count <= '0;
        end else begin
            bitslip <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg  <= ST_WAIT;
                        busy       <= 1'b1;
                        fail       <= 1'b0;
                        slip_count <= '0;
                        match_reg  <= '0;
                        settle_reg <= SETTLE_LD;
                    end
                end
                ST_WAIT: begin
                    // One extra cycle at zero lets the ISERDES pipeline fully flush.
                    if (settle_reg == 4'd0) begin
                        state_reg <= ST_CHECK;
                    end else begin
                        settle_reg <= settle_reg - 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (word_match) begin
                        if (match_reg == MATCH_LAST) begin
                            state_reg <= ST_LOCKED;
                            busy      <= 1'b0;
                            locked    <= 1'b1;
                            loss_reg  <= '0;
                            match_reg <= '0;
                        end else begin
                            match_reg <= match_reg + 8'd1;
                        end
                    end else begin
                        match_reg <= '0;
                        if (slip_count == SLIP_LIMIT) begin
                            state_reg <= ST_FAIL;
                            busy      <= 1'b0;
                            fail      <= 1'b1;
                        end else begin
                            state_reg  <= ST_SLIP;
                            bitslip    <= 1'b1;
                            slip_count <= slip_count + 4'd1;
                            settle_reg <= SETTLE_LD;
                        end
                    end
                end
                ST_SLIP: begin
                    state_reg <= ST_WAIT;
                end
                ST_LOCKED: begin
                    if (!word_match && loss_reg == LOSS_LAST) begin
                        loss_reg <= '0;
                    end else if (!word_match) begin
                        loss_reg <= loss_reg + 4'd1;
                    end else begin
                        loss_reg <= '0;
                    end
                    // A start request wins over a simultaneous loss-of-lock.
                    if (start || (!word_match && loss_reg == LOSS_LAST && retrain_en)) begin
                        state_reg  <= ST_WAIT;
                        locked     <= 1'b0;
                        busy       <= 1'b1;
                        slip_count <= '0;
                        match_reg  <= '0;
                        settle_reg <= SETTLE_LD;
                    end else if (!word_match && loss_reg == LOSS_LAST) begin
                        state_reg <= ST_IDLE;
                        locked    <= 1'b0;
                    end
                end
                ST_FAIL: begin
                    if (start) begin
                        state_reg  <= ST_WAIT;
                        busy       <= 1'b1;
                        fail       <= 1'b0;
                        slip_count <= '0;
                        match_reg  <= '0;
                        settle_reg <= SETTLE_LD;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALIGN_STATS_EN
    logic loss_event;

    assign loss_event = (state_reg == ST_LOCKED) && !word_match && (loss_reg == LOSS_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            relock_count <= '0;
        end else if (loss_event && relock_count != 8'hff) begin
            relock_count <= relock_count + 8'd1;
        end
    end
`else
    assign relock_count = 8'h00;
`endif

endmodule

// File: tb/tb_adc_align_ctrl.sv
// Self-checking bench for adc_align_ctrl: directed scenarios plus randomized
// training runs checked against a rotation model of the ISERDES bitslip.
module tb_adc_align_ctrl;

    localparam logic [7:0] PATTERN   = 8'hf0;
    localparam int         SETTLE    = 4;
    localparam int         MATCH_CNT = 16;
    localparam int         MAX_SLIPS = 8;
    localparam int         LOSS_CNT  = 4;
    localparam int         BOUND     = 2000;
`ifdef ALIGN_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       retrain_en;
    logic [7:0] frame_word;
    logic       bitslip;
    logic       busy;
    logic       locked;
    logic       fail;
    logic [3:0] slip_count;
    logic [7:0] relock_count;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pulses   = 0;
    int last_pulse = 0;
    int loss_events = 0;
    logic prev_bs = 1'b0;

    adc_align_ctrl #(
        .PATTERN(PATTERN), .SETTLE(SETTLE), .MATCH_CNT(MATCH_CNT),
        .MAX_SLIPS(MAX_SLIPS), .LOSS_CNT(LOSS_CNT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .retrain_en(retrain_en),
        .frame_word(frame_word), .bitslip(bitslip), .busy(busy), .locked(locked),
        .fail(fail), .slip_count(slip_count), .relock_count(relock_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rol(input logic [7:0] w);
        return {w[6:0], w[7]};
    endfunction

    function automatic logic [7:0] rotr(input logic [7:0] w);
        return {w[0], w[7:1]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; sample after the edge and let the modelled ISERDES slip on each pulse.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bitslip) begin
            check("bitslip_width", 32'(prev_bs), 32'd0);
            if (pulses > 0) check("bitslip_spacing", 32'((cyc - last_pulse) >= SETTLE + 2), 32'd1);
            pulses++;
            last_pulse = cyc;
            frame_word = rol(frame_word);
        end
        prev_bs = bitslip;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bitslip"}, 32'(bitslip), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_fail"}, 32'(fail), 32'd0);
        check({tag, "_slip_count"}, 32'(slip_count), 32'd0);
        check({tag, "_relock_count"}, 32'(relock_count), 32'd0);
    endtask

    // Model: count rotations needed to reach PATTERN, giving up after MAX_SLIPS.
    task automatic run_training(input logic [7:0] word);
        logic [7:0] w;
        int exp_slips;
        bit exp_lock;
        int lat;
        w = word;
        exp_slips = 0;
        while (w != PATTERN && exp_slips < MAX_SLIPS) begin
            w = rol(w);
            exp_slips++;
        end
        exp_lock = (w == PATTERN);

        pulses = 0;
        frame_word = word;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_fail_clear", 32'(fail), 32'd0);
        check("start_locked_clear", 32'(locked), 32'd0);
        lat = 0;
        while (!(locked || fail) && lat < BOUND) begin
            tick();
            lat++;
        end
        check("train_timeout", 32'(lat < BOUND), 32'd1);
        if (exp_lock) begin
            check("train_locked", 32'(locked), 32'd1);
            check("train_fail", 32'(fail), 32'd0);
            check("train_slip_count", 32'(slip_count), 32'(exp_slips));
            check("train_pulses", 32'(pulses), 32'(exp_slips));
            if (exp_slips == 0) check("lock_latency", 32'(lat), 32'(SETTLE + MATCH_CNT + 1));
        end else begin
            check("train_fail", 32'(fail), 32'd1);
            check("train_locked", 32'(locked), 32'd0);
            check("train_slip_count", 32'(slip_count), 32'(MAX_SLIPS));
            check("train_pulses", 32'(pulses), 32'(MAX_SLIPS));
        end
        check("train_busy", 32'(busy), 32'd0);
        $display("txn train word=%02h slips=%0d lock=%0d latency=%0d", word, pulses, locked, lat);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        start = 1'b0;
        retrain_en = 1'b0;
        frame_word = PATTERN;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        run_training(8'hf0);
        run_training(8'he1);
        run_training(8'h55);
        run_training(8'hf0);

        // Short mismatch burst must not drop lock.
        frame_word = 8'h00;
        repeat (LOSS_CNT - 1) begin
            tick();
            check("burst_locked", 32'(locked), 32'd1);
        end
        frame_word = PATTERN;
        tick();
        check("burst_recover", 32'(locked), 32'd1);
        $display("txn short mismatch burst locked=%0d", locked);

        // Loss of lock with auto-retrain; a start during retraining is ignored.
        retrain_en = 1'b1;
        frame_word = 8'h00;
        repeat (LOSS_CNT - 1) tick();
        check("loss_pre_locked", 32'(locked), 32'd1);
        tick();
        loss_events++;
        check("loss_locked", 32'(locked), 32'd0);
        check("loss_busy", 32'(busy), 32'd1);
        check("loss_relock", 32'(relock_count), STATS_ON ? 32'(loss_events) : 32'd0);
        frame_word = PATTERN;
        lat = 0;
        while (!locked && lat < BOUND) begin
            if (lat == 5) start = 1'b1;
            tick();
            start = 1'b0;
            lat++;
        end
        check("retrain_latency", 32'(lat), 32'(SETTLE + MATCH_CNT + 1));
        $display("txn loss retrain latency=%0d relock=%0d", lat, relock_count);

        // Loss without retrain returns to idle and stays there.
        retrain_en = 1'b0;
        frame_word = 8'h00;
        repeat (LOSS_CNT) tick();
        loss_events++;
        check("idle_loss_locked", 32'(locked), 32'd0);
        check("idle_loss_busy", 32'(busy), 32'd0);
        frame_word = PATTERN;
        repeat (30) tick();
        check("idle_stays_locked", 32'(locked), 32'd0);
        check("idle_stays_busy", 32'(busy), 32'd0);
        check("idle_relock", 32'(relock_count), STATS_ON ? 32'(loss_events) : 32'd0);
        $display("txn loss to idle relock=%0d", relock_count);

        // Reset landing in the SLIP cycle.
        frame_word = 8'he1;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!bitslip && lat < BOUND) begin
            tick();
            lat++;
        end
        check("slip_seen", 32'(bitslip), 32'd1);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("midslip");
        rst_n = 1'b1;
        loss_events = 0;
        repeat (5) tick();
        check("post_reset_busy", 32'(busy), 32'd0);
        $display("txn reset during slip");

        for (int i = 0; i < 8; i++) begin
            int r;
            logic [7:0] w;
            r = $urandom_range(0, 9);
            w = PATTERN;
            if (r < 8) begin
                for (int k = 0; k < r; k++) w = rotr(w);
            end else begin
                w = 8'($urandom);
            end
            run_training(w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
